// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared opcodes, instruction field positions and fetch FSM states
package cpu16_pkg;

    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_J     = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RA_HI  = 11;
    localparam int RA_LO  = 8;
    localparam int RB_HI  = 7;
    localparam int RB_LO  = 4;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;
    localparam int JT_HI  = 11;
    localparam int JT_LO  = 0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        EXEC,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: selects jump, taken-branch or sequential next PC
module next_pc_calc
    import cpu16_pkg::*;
#(
    parameter int PC_W = 12
) (
    input  logic [PC_W-1:0] pc,
    input  logic [3:0]      opcode,
    input  logic [3:0]      imm4,
    input  logic [11:0]     jtarget,
    input  logic            branch_en,
    input  logic            jump_en,
    input  logic            alu_zero,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] jump_pc;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_pc;
    logic            taken;

    // Narrow PCs take the low target bits; wide PCs keep their upper page
    generate
        if (PC_W <= 12) begin : g_narrow
            assign jump_pc = jtarget[PC_W-1:0];
        end else begin : g_wide
            assign jump_pc = {pc[PC_W-1:12], jtarget};
        end
    endgenerate

    assign seq_pc  = pc + PC_W'(1);
    assign br_pc   = seq_pc + {{(PC_W-4){imm4[3]}}, imm4};
    assign taken   = branch_en && ((opcode == OP_BEQ && alu_zero) || (opcode == OP_BNE && !alu_zero));
    assign next_pc = jump_en ? jump_pc : taken ? br_pc : seq_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, req/ack instruction fetch, IR decode fields and next-PC selection
module instr_fetch_unit
    import cpu16_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [3:0]         opcode,
    output logic [3:0]         funct,
    output logic [3:0]         rs_a,
    output logic [3:0]         rs_b,
    output logic [3:0]         imm4,
    output logic [11:0]        jtarget,
    input  logic               branch_en,
    input  logic               jump_en,
    input  logic               alu_zero,
    input  logic               exec_stall,
    output logic [PC_W-1:0]    pc_out,
    output logic               halted
);

    fetch_state_t       state, state_n;
    logic [PC_W-1:0]    pc, pc_n, npc;
    logic [INSTR_W-1:0] ir, ir_n;

    // IR only changes on the ack edge, so its fields hold outside EXEC
    assign opcode    = ir[OPC_HI:OPC_LO];
    assign rs_a      = ir[RA_HI:RA_LO];
    assign rs_b      = ir[RB_HI:RB_LO];
    assign imm4      = ir[IMM_HI:IMM_LO];
    assign funct     = ir[IMM_HI:IMM_LO];
    assign jtarget   = ir[JT_HI:JT_LO];
    assign pc_out    = pc;
    assign imem_addr = pc;

    next_pc_calc #(.PC_W(PC_W)) u_next_pc (
        .pc        (pc),
        .opcode    (opcode),
        .imm4      (imm4),
        .jtarget   (jtarget),
        .branch_en (branch_en),
        .jump_en   (jump_en),
        .alu_zero  (alu_zero),
        .next_pc   (npc)
    );

    // State, PC and IR registers; reset clears everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
        end
    end

    // Fetch sequencing: request, capture on ack, execute, advance or halt
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ir_n        = ir;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: state_n = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_n    = imem_rdata;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!exec_stall) begin
                    if (opcode == OP_HALT) begin
                        state_n = HALT;
                    end else begin
                        pc_n    = npc;
                        state_n = REQ;
                    end
                end
            end
            HALT: halted = 1'b1;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch timing, next-PC selection, stall, halt and reset
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [3:0]  opcode, funct, rs_a, rs_b, imm4;
    logic [11:0] jtarget;
    logic        branch_en, jump_en, alu_zero, exec_stall;
    logic [11:0] pc_out;
    logic        halted;

    logic [15:0] mem [0:4095];
    int          ack_delay = 0;
    int          wcnt = 0;
    int          checks = 0;
    int          passes = 0;

    instr_fetch_unit #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .funct       (funct),
        .rs_a        (rs_a),
        .rs_b        (rs_b),
        .imm4        (imm4),
        .jtarget     (jtarget),
        .branch_en   (branch_en),
        .jump_en     (jump_en),
        .alu_zero    (alu_zero),
        .exec_stall  (exec_stall),
        .pc_out      (pc_out),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Memory model: acks after ack_delay cycles of a pending request
    always @(posedge clk) wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;
    assign imem_ack   = imem_req && (wcnt >= ack_delay);
    assign imem_rdata = mem[imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_exec(input string tag, input logic [11:0] exp_pc, input int exp_n);
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_cycles"}, n, exp_n);
        check({tag, "_pc"}, pc_out, exp_pc);
    endtask

    task automatic to_req(input string tag, input logic [11:0] exp_addr);
        @(negedge clk);
        branch_en  = 1'b0;
        jump_en    = 1'b0;
        alu_zero   = 1'b0;
        exec_stall = 1'b0;
        check({tag, "_req"}, imem_req, 1);
        check({tag, "_addr"}, imem_addr, exp_addr);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[0]      = 16'h0120;
        mem[1]      = 16'h0230;
        mem[2]      = 16'h0340;
        mem[3]      = 16'h0450;
        mem[4]      = 16'h0560;
        mem[5]      = 16'h412E;
        mem[6]      = 16'h012E;
        mem[7]      = 16'h5003;
        mem[11]     = 16'h60A0;
        mem[12'h0A0] = 16'h6FFF;
        mem[12'hFFF] = 16'h3456;
        branch_en  = 1'b0;
        jump_en    = 1'b0;
        alu_zero   = 1'b0;
        exec_stall = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc_out, 0);
        check("rst_opcode", opcode, 0);
        check("rst_jtarget", jtarget, 0);
        rst_n = 1'b1;
        check("idle_req", imem_req, 0);
        wait_exec("seq0", 12'h000, 2);
        to_req("seq0", 12'h001);
        for (int i = 1; i <= 4; i++) begin
            wait_exec($sformatf("seq%0d", i), 12'(i), 1);
            to_req($sformatf("seq%0d", i), 12'(i + 1));
        end
        wait_exec("beq_t", 12'h005, 1);
        check("beq_opcode", opcode, 4'h4);
        check("beq_rs_a", rs_a, 4'h1);
        check("beq_rs_b", rs_b, 4'h2);
        check("beq_imm4", imm4, 4'hE);
        check("beq_funct", funct, 4'hE);
        branch_en = 1'b1;
        alu_zero  = 1'b1;
        to_req("beq_t", 12'h004);
        wait_exec("seq4b", 12'h004, 1);
        to_req("seq4b", 12'h005);
        wait_exec("beq_nt", 12'h005, 1);
        branch_en = 1'b1;
        to_req("beq_nt", 12'h006);
        wait_exec("br_rtype", 12'h006, 1);
        branch_en = 1'b1;
        alu_zero  = 1'b1;
        to_req("br_rtype", 12'h007);
        wait_exec("bne_t", 12'h007, 1);
        branch_en = 1'b1;
        to_req("bne_t", 12'h00B);
        wait_exec("jmp", 12'h00B, 1);
        check("jmp_jtarget", jtarget, 12'h0A0);
        jump_en   = 1'b1;
        branch_en = 1'b1;
        alu_zero  = 1'b1;
        to_req("jmp", 12'h0A0);
        wait_exec("stall", 12'h0A0, 1);
        exec_stall = 1'b1;
        jump_en    = 1'b1;
        @(negedge clk);
        check("stall1_valid", instr_valid, 1);
        check("stall1_pc", pc_out, 12'h0A0);
        @(negedge clk);
        check("stall2_valid", instr_valid, 1);
        check("stall2_pc", pc_out, 12'h0A0);
        exec_stall = 1'b0;
        to_req("stall_jmp", 12'hFFF);
        wait_exec("wrap", 12'hFFF, 1);
        to_req("wrap", 12'h000);
        mem[1]    = 16'hF000;
        ack_delay = 3;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wait%0d_req", k), imem_req, 1);
            check($sformatf("wait%0d_addr", k), imem_addr, 12'h000);
            check($sformatf("wait%0d_valid", k), instr_valid, 0);
            check($sformatf("wait%0d_opcode", k), opcode, 4'h3);
            @(negedge clk);
        end
        check("ackcyc_ack", imem_ack, 1);
        check("ackcyc_opcode", opcode, 4'h3);
        wait_exec("delayed", 12'h000, 1);
        check("delayed_rs_a", rs_a, 4'h1);
        ack_delay = 0;
        to_req("delayed", 12'h001);
        wait_exec("halt", 12'h001, 1);
        check("halt_opcode", opcode, 4'hF);
        @(negedge clk);
        check("halt_halted", halted, 1);
        check("halt_req", imem_req, 0);
        check("halt_valid", instr_valid, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req || !halted) bad++;
        end
        check("halt_hold", bad, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        ack_delay = 5;
        @(negedge clk);
        check("mid_req", imem_req, 1);
        check("mid_ack", imem_ack, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_opcode", opcode, 0);
        check("mid_rst_pc", pc_out, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        ack_delay = 0;
        check("mid_idle_req", imem_req, 0);
        wait_exec("refetch", 12'h000, 2);
        check("refetch_opcode", opcode, 4'h0);
        to_req("refetch", 12'h001);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
